// File: rtl/player_object_mixer_pkg.sv
// Purpose: shared constants, player register bundle and FSM state type for the player/object mixer.
// Latency: n/a (types and constants only).
// Backpressure: n/a; the pixel pipeline never stalls.
package player_object_mixer_pkg;

    localparam int IMAGE_WIDTH_DEF = 640;
    localparam int BASE_PIX_DEF    = 4;   // 640 pixels / 160 colour clocks

    localparam logic [1:0] SIZE_1X = 2'd0;
    localparam logic [1:0] SIZE_2X = 2'd1;
    localparam logic [1:0] SIZE_4X = 2'd2;

    localparam int CX_P0P1 = 0;
    localparam int CX_P0PF = 1;
    localparam int CX_P1PF = 2;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_DRAW = 1'b1
    } ser_state_t;

    // One player's CPU-visible registers, shadowed per line.
    typedef struct packed {
        logic [7:0] grp;
        logic [9:0] pos;
        logic [6:0] color;
        logic       refl;
        logic [1:0] size;
    } player_cfg_t;

    // Width multiplier; size code 3 aliases to 4x.
    function automatic int size_scale(input logic [1:0] size);
        case (size)
            SIZE_1X: size_scale = 1;
            SIZE_2X: size_scale = 2;
            SIZE_4X: size_scale = 4;
            default: size_scale = 4;
        endcase
    endfunction

endpackage

// File: rtl/player_object_mixer_if.sv
// Purpose: pixel-stream, player-register and result bundle between playfield stage, mixer and hdmi.
// Latency: n/a (wiring only).
// Backpressure: none; master drives one pixel per clock, slave returns colour and collision flags.
interface player_object_mixer_if;
    logic       in_image;
    logic [9:0] pos_x;
    logic [6:0] pf_color;
    logic       pf_is_fg;
    logic [7:0] grp0;
    logic [7:0] grp1;
    logic [9:0] pos_p0;
    logic [9:0] pos_p1;
    logic [6:0] color_p0;
    logic [6:0] color_p1;
    logic       refp0;
    logic       refp1;
    logic [1:0] size_p0;
    logic [1:0] size_p1;
    logic       pf_priority;
    logic       cxclr_toggle;
    logic [6:0] color_out;
    logic [2:0] collisions;

    modport master (
        output in_image, pos_x, pf_color, pf_is_fg, grp0, grp1, pos_p0, pos_p1,
               color_p0, color_p1, refp0, refp1, size_p0, size_p1, pf_priority,
               cxclr_toggle,
        input  color_out, collisions
    );

    modport slave (
        input  in_image, pos_x, pf_color, pf_is_fg, grp0, grp1, pos_p0, pos_p1,
               color_p0, color_p1, refp0, refp1, size_p0, size_p1, pf_priority,
               cxclr_toggle,
        output color_out, collisions
    );
endinterface

// File: rtl/player_object_mixer_serializer.sv
// Purpose: one player sprite serialiser (shadow regs, IDLE/DRAW FSM, bit/sub counters, reflect select).
// Latency: combinational active for the current pos_x; draw state advances each clock.
// Backpressure: none; ports clk_pixel/reset, in_image/pos_x stream, cfg_in registers -> active, color.
module player_serializer
    import player_object_mixer_pkg::*;
#(
    parameter int IMAGE_WIDTH = IMAGE_WIDTH_DEF,
    parameter int BASE_PIX    = BASE_PIX_DEF
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        in_image,
    input  logic [9:0]  pos_x,
    input  player_cfg_t cfg_in,
    output logic        active,
    output logic [6:0]  color
);

    localparam int          SUB_W = $clog2(BASE_PIX * 4);
    localparam logic [10:0] IW    = 11'(IMAGE_WIDTH);

    player_cfg_t      cfg_q, cfg_d;
    ser_state_t       state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    logic             trigger;
    logic             drawing;
    logic [2:0]       cur_bit;
    logic [2:0]       sel_idx;
    logic [SUB_W-1:0] cur_sub;
    logic [SUB_W-1:0] sub_last;

    always_comb begin
        cfg_d    = in_image ? cfg_q : cfg_in;
        state_d  = state_q;
        bit_d    = bit_q;
        sub_d    = sub_q;

        // A position match starts (or restarts) the draw on this very pixel,
        // so the sprite's first bit is visible at pos_x == pos.
        trigger  = in_image && (pos_x == cfg_q.pos) && ({1'b0, cfg_q.pos} < IW);
        drawing  = trigger || (in_image && (state_q == SER_DRAW));
        cur_bit  = trigger ? 3'd0 : bit_q;
        cur_sub  = trigger ? '0 : sub_q;
        sub_last = SUB_W'(BASE_PIX * size_scale(cfg_q.size) - 1);
        sel_idx  = cfg_q.refl ? cur_bit : (3'd7 - cur_bit);
        active   = drawing && cfg_q.grp[sel_idx];

        if (!in_image) begin
            // Leaving the visible region kills any draw: no wrap to the next line.
            state_d = SER_IDLE;
            bit_d   = 3'd0;
            sub_d   = '0;
        end else if (drawing) begin
            if (cur_sub == sub_last) begin
                sub_d = '0;
                if (cur_bit == 3'd7) begin
                    state_d = SER_IDLE;
                    bit_d   = 3'd0;
                end else begin
                    state_d = SER_DRAW;
                    bit_d   = cur_bit + 3'd1;
                end
            end else begin
                state_d = SER_DRAW;
                bit_d   = cur_bit;
                sub_d   = cur_sub + SUB_W'(1);
            end
        end
    end

    assign color = cfg_q.color;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cfg_q   <= '0;
            state_q <= SER_IDLE;
            bit_q   <= 3'd0;
            sub_q   <= '0;
        end else begin
            cfg_q   <= cfg_d;
            state_q <= state_d;
            bit_q   <= bit_d;
            sub_q   <= sub_d;
        end
    end

endmodule

// File: rtl/player_object_mixer.sv
// Purpose: merges P0/P1 sprites with playfield colour by priority and latches sticky collision flags.
// Latency: 1 clock from pos_x/pf inputs to color_out; collisions clear 3 clocks after a toggle edge.
// Backpressure: none; ports clk_pixel, reset, bus (slave: pixel stream + player regs in, colour/flags out).
module player_object_mixer
    import player_object_mixer_pkg::*;
#(
    parameter int IMAGE_WIDTH = IMAGE_WIDTH_DEF,
    parameter int BASE_PIX    = BASE_PIX_DEF
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    player_object_mixer_if.slave  bus
);

    player_cfg_t cfg0, cfg1;
    logic        active0, active1;
    logic [6:0]  col0, col1;

    logic        pfp_q, pfp_d;
    logic        tog_meta_q, tog_meta_d;
    logic        tog_sync_q, tog_sync_d;
    logic        tog_prev_q, tog_prev_d;
    logic [6:0]  color_q, color_d;
    logic [2:0]  cx_q, cx_d;

    logic        clear_pulse;
    logic [2:0]  set_bits;

    assign cfg0 = '{grp: bus.grp0, pos: bus.pos_p0, color: bus.color_p0,
                    refl: bus.refp0, size: bus.size_p0};
    assign cfg1 = '{grp: bus.grp1, pos: bus.pos_p1, color: bus.color_p1,
                    refl: bus.refp1, size: bus.size_p1};

    player_serializer #(.IMAGE_WIDTH(IMAGE_WIDTH), .BASE_PIX(BASE_PIX)) u_p0 (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .in_image  (bus.in_image),
        .pos_x     (bus.pos_x),
        .cfg_in    (cfg0),
        .active    (active0),
        .color     (col0)
    );

    player_serializer #(.IMAGE_WIDTH(IMAGE_WIDTH), .BASE_PIX(BASE_PIX)) u_p1 (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .in_image  (bus.in_image),
        .pos_x     (bus.pos_x),
        .cfg_in    (cfg1),
        .active    (active1),
        .color     (col1)
    );

    always_comb begin
        pfp_d      = bus.in_image ? pfp_q : bus.pf_priority;
        tog_meta_d = bus.cxclr_toggle;
        tog_sync_d = tog_meta_q;
        tog_prev_d = tog_sync_q;
        // Either edge of the synchronised toggle level is one clear request.
        clear_pulse = tog_sync_q ^ tog_prev_q;

        set_bits = 3'b000;
        if (bus.in_image) begin
            set_bits[CX_P0P1] = active0 && active1;
            set_bits[CX_P0PF] = active0 && bus.pf_is_fg;
            set_bits[CX_P1PF] = active1 && bus.pf_is_fg;
        end
        // A hit in the clear cycle survives the clear.
        cx_d = clear_pulse ? set_bits : (cx_q | set_bits);

        color_d = 7'd0;
        if (bus.in_image) begin
            if (pfp_q && bus.pf_is_fg) color_d = bus.pf_color;
            else if (active0)          color_d = col0;
            else if (active1)          color_d = col1;
            else                       color_d = bus.pf_color;
        end
    end

    assign bus.color_out  = color_q;
    assign bus.collisions = cx_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pfp_q      <= 1'b0;
            tog_meta_q <= 1'b0;
            tog_sync_q <= 1'b0;
            tog_prev_q <= 1'b0;
            color_q    <= 7'd0;
            cx_q       <= 3'b000;
        end else begin
            pfp_q      <= pfp_d;
            tog_meta_q <= tog_meta_d;
            tog_sync_q <= tog_sync_d;
            tog_prev_q <= tog_prev_d;
            color_q    <= color_d;
            cx_q       <= cx_d;
        end
    end

endmodule

// File: tb/tb_player_object_mixer.sv
// Purpose: directed self-checking bench for player_object_mixer.
// Latency: expects color_out one clock after each pixel, collision clear three clocks after a toggle.
// Backpressure: none; one pixel driven per clock.
module tb_player_object_mixer;
    localparam logic [6:0] PF = 7'h11;
    localparam logic [6:0] C0 = 7'h22;
    localparam logic [6:0] C1 = 7'h33;

    logic clk_pixel = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    player_object_mixer_if bus();

    player_object_mixer dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, then sample its registered result just after the edge.
    task automatic pix(input logic [9:0] x, input logic img, input logic fg);
        bus.pos_x    = x;
        bus.in_image = img;
        bus.pf_is_fg = fg;
        @(posedge clk_pixel);
        #1;
    endtask

    // One blank pixel (reloads shadows) then a full visible line with per-pixel checks.
    task automatic run_line(input string tag, input int lo0, input int hi0,
                            input int lo1, input int hi1, input int flo, input int fhi,
                            input logic pfp, input int tog_x,
                            input logic [2:0] cx_mid, input logic [2:0] cx_end);
        logic       fg;
        logic [6:0] exp;
        pix(10'd0, 1'b0, 1'b0);
        chk({tag, " blank"}, bus.color_out, 7'd0);
        for (int x = 0; x < 640; x++) begin
            fg = (x >= flo) && (x <= fhi);
            if (x == tog_x) bus.cxclr_toggle = ~bus.cxclr_toggle;
            pix(10'(x), 1'b1, fg);
            if (pfp && fg)                   exp = PF;
            else if (x >= lo0 && x <= hi0)   exp = C0;
            else if (x >= lo1 && x <= hi1)   exp = C1;
            else                             exp = PF;
            chk($sformatf("%s x=%0d", tag, x), bus.color_out, exp);
            if (tog_x >= 0 && x == tog_x + 2)
                chk({tag, " cx_mid"}, {4'd0, bus.collisions}, {4'd0, cx_mid});
        end
        chk({tag, " cx_end"}, {4'd0, bus.collisions}, {4'd0, cx_end});
    endtask

    initial begin
        reset            = 1'b1;
        bus.in_image     = 1'b0;
        bus.pos_x        = 10'd0;
        bus.pf_color     = PF;
        bus.pf_is_fg     = 1'b0;
        bus.grp0         = 8'hF0;
        bus.grp1         = 8'h00;
        bus.pos_p0       = 10'd100;
        bus.pos_p1       = 10'd0;
        bus.color_p0     = C0;
        bus.color_p1     = C1;
        bus.refp0        = 1'b0;
        bus.refp1        = 1'b0;
        bus.size_p0      = 2'd0;
        bus.size_p1      = 2'd0;
        bus.pf_priority  = 1'b0;
        bus.cxclr_toggle = 1'b0;

        repeat (3) pix(10'd0, 1'b0, 1'b0);
        chk("reset color", bus.color_out, 7'd0);
        chk("reset cx", {4'd0, bus.collisions}, 7'd0);
        reset = 1'b0;

        // Basic serialisation, 1x, then reflected.
        run_line("p0_norm", 100, 115, -1, -1, -1, -1, 1'b0, -1, 3'b000, 3'b000);
        bus.refp0 = 1'b1;
        run_line("p0_refl", 116, 131, -1, -1, -1, -1, 1'b0, -1, 3'b000, 3'b000);

        // 2x P0, 4x P1 truncated at the right edge, then a clean next line.
        bus.refp0   = 1'b0;
        bus.grp0    = 8'h80;
        bus.size_p0 = 2'd1;
        bus.pos_p0  = 10'd10;
        bus.grp1    = 8'hFF;
        bus.size_p1 = 2'd2;
        bus.pos_p1  = 10'd600;
        run_line("p1_trunc", 10, 17, 600, 639, -1, -1, 1'b0, -1, 3'b000, 3'b000);
        bus.grp1    = 8'h80;
        bus.size_p1 = 2'd3;
        run_line("p1_4x", 10, 17, 600, 615, -1, -1, 1'b0, -1, 3'b000, 3'b000);

        // Full overlap with playfield: all three flags.
        bus.grp0    = 8'hFF;
        bus.grp1    = 8'hFF;
        bus.size_p0 = 2'd0;
        bus.size_p1 = 2'd0;
        bus.pos_p0  = 10'd200;
        bus.pos_p1  = 10'd200;
        run_line("cx_set", 200, 231, 200, 231, 200, 215, 1'b0, -1, 3'b000, 3'b111);

        // Clear lands exactly three edges after the toggle.
        bus.cxclr_toggle = ~bus.cxclr_toggle;
        pix(10'd0, 1'b0, 1'b0);
        pix(10'd0, 1'b0, 1'b0);
        chk("cx_clr_hold", {4'd0, bus.collisions}, {4'd0, 3'b111});
        pix(10'd0, 1'b0, 1'b0);
        chk("cx_clr_done", {4'd0, bus.collisions}, {4'd0, 3'b000});

        // Clear coinciding with a P0/P1 overlap: only that flag survives.
        run_line("cx_setwin", 200, 231, 200, 231, 200, 203, 1'b0, 205, 3'b001, 3'b001);

        // Playfield priority above and below players.
        bus.grp1        = 8'h00;
        bus.pf_priority = 1'b1;
        run_line("pf_above", 200, 231, -1, -1, 200, 215, 1'b1, -1, 3'b000, 3'b011);
        bus.pf_priority = 1'b0;
        run_line("pf_below", 200, 231, -1, -1, 200, 215, 1'b0, -1, 3'b000, 3'b011);

        // Mid-line position write is deferred to the next line.
        bus.grp0   = 8'hF0;
        bus.pos_p0 = 10'd100;
        pix(10'd0, 1'b0, 1'b0);
        for (int x = 0; x < 640; x++) begin
            if (x == 50) bus.pos_p0 = 10'd300;
            pix(10'(x), 1'b1, 1'b0);
            chk($sformatf("shadow_old x=%0d", x), bus.color_out,
                (x >= 100 && x <= 115) ? C0 : PF);
        end
        run_line("shadow_new", 300, 315, -1, -1, -1, -1, 1'b0, -1, 3'b000, 3'b011);

        // Reset in the middle of a draw.
        bus.pos_p0 = 10'd110;
        pix(10'd0, 1'b0, 1'b0);
        for (int x = 0; x < 120; x++) begin
            pix(10'(x), 1'b1, 1'b1);
            chk($sformatf("pre_rst x=%0d", x), bus.color_out,
                (x >= 110) ? C0 : PF);
        end
        chk("pre_rst cx", {4'd0, bus.collisions}, {4'd0, 3'b011});
        reset = 1'b1;
        pix(10'd120, 1'b1, 1'b1);
        chk("rst color", bus.color_out, 7'd0);
        chk("rst cx", {4'd0, bus.collisions}, {4'd0, 3'b000});
        reset = 1'b0;
        for (int x = 121; x < 140; x++) begin
            pix(10'(x), 1'b1, 1'b1);
            chk($sformatf("post_rst x=%0d", x), bus.color_out, PF);
        end
        chk("post_rst cx", {4'd0, bus.collisions}, {4'd0, 3'b000});
        run_line("resume", 110, 125, -1, -1, -1, -1, 1'b0, -1, 3'b000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
